// File: rtl/ddr3_cmd_sequencer.sv
// ddr3_cmd_sequencer
//   Brings a DDR3 device out of reset (reset hold, CKE hold, MR2/MR3/MR1/MR0,
//   ZQCL), then serves single read/write requests as ACT + RD/WR with
//   auto-precharge, and inserts periodic REF commands.
// Ports
//   sys_clk, sys_rst_n           : clock, asynchronous active-low reset
//   req_valid/ready/we/ba/row/col: request handshake and address
//   ddr3_reset_n, ddr3_cke       : DRAM reset and clock enable
//   ddr3_cs_n/ras_n/cas_n/we_n   : command pins
//   ddr3_ba, ddr3_addr           : bank and address pins
//   init_calib_complete          : high once initialisation has finished
//   wr_data_en, rd_capture       : 4-cycle data strobes, CWL/CL after the CAS
module ddr3_cmd_sequencer #(
  parameter int ROW_WIDTH  = 14,
  parameter int COL_WIDTH  = 10,
  parameter int T_INIT     = 200,
  parameter int T_MOD      = 12,
  parameter int T_ZQ       = 512,
  parameter int T_RCD      = 6,
  parameter int T_CAS2IDLE = 20,
  parameter int T_RFC      = 64,
  parameter int T_REFI     = 3120,
  parameter int CL         = 6,
  parameter int CWL        = 5
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_ba,
  input  logic [ROW_WIDTH-1:0] req_row,
  input  logic [COL_WIDTH-1:0] req_col,
  output logic                 ddr3_reset_n,
  output logic                 ddr3_cke,
  output logic                 ddr3_cs_n,
  output logic                 ddr3_ras_n,
  output logic                 ddr3_cas_n,
  output logic                 ddr3_we_n,
  output logic [2:0]           ddr3_ba,
  output logic [ROW_WIDTH-1:0] ddr3_addr,
  output logic                 init_calib_complete,
  output logic                 wr_data_en,
  output logic                 rd_capture
);

  typedef enum logic [2:0] {
    RST_HOLD, CKE_HOLD, MRS, ZQ, IDLE, ACT_WAIT, CAS_WAIT, REF_WAIT
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_ZQ  = 4'b0110;

  localparam logic [15:0] INIT_LAST = 16'(T_INIT - 1);
  localparam logic [15:0] MOD_LAST  = 16'(T_MOD);
  localparam logic [15:0] ZQ_LAST   = 16'(T_ZQ - 1);
  localparam logic [15:0] RCD_LAST  = 16'(T_RCD);
  localparam logic [15:0] C2I_LAST  = 16'(T_CAS2IDLE);
  localparam logic [15:0] RFC_LAST  = 16'(T_RFC - 1);
  localparam logic [15:0] REFI_LAST = 16'(T_REFI - 1);

  state_t                 state, state_nxt;
  logic [15:0]            cnt, cnt_nxt;
  logic [1:0]             mrs_idx, mrs_idx_nxt;
  logic                   init_done, init_done_nxt;
  logic [15:0]            ref_cnt;
  logic                   ref_pend, ref_expire, ref_issue;
  logic                   accept, wr_issue, rd_issue, strobe_busy;
  logic                   lat_we;
  logic [2:0]             lat_ba;
  logic [COL_WIDTH-1:0]   lat_col;
  logic [CWL+2:0]         wr_sr;
  logic [CL+2:0]          rd_sr;
  logic [3:0]             cmd;

  // A new ACT waits until the previous burst strobes have fully drained.
  assign strobe_busy = (|wr_sr) | (|rd_sr);
  assign ref_expire  = init_done && (ref_cnt == REFI_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= RST_HOLD;
      cnt       <= '0;
      mrs_idx   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mrs_idx   <= mrs_idx_nxt;
      init_done <= init_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mrs_idx_nxt   = mrs_idx;
    init_done_nxt = init_done;
    cmd           = C_NOP;
    ddr3_ba       = '0;
    ddr3_addr     = '0;
    ddr3_reset_n  = 1'b1;
    ddr3_cke      = 1'b1;
    req_ready     = 1'b0;
    accept        = 1'b0;
    ref_issue     = 1'b0;
    wr_issue      = 1'b0;
    rd_issue      = 1'b0;
    case (state)
      RST_HOLD: begin
        ddr3_reset_n = 1'b0;
        ddr3_cke     = 1'b0;
        if (cnt == INIT_LAST) begin
          state_nxt = CKE_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      CKE_HOLD: begin
        ddr3_cke = 1'b0;
        if (cnt == INIT_LAST) begin
          state_nxt   = MRS;
          cnt_nxt     = '0;
          mrs_idx_nxt = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      MRS: begin
        // cnt==0 issues the mode register write, then T_MOD NOP cycles follow.
        if (cnt == '0) begin
          cmd = C_MRS;
          case (mrs_idx)
            2'd0:    ddr3_ba = 3'd2;
            2'd1:    ddr3_ba = 3'd3;
            2'd2:    ddr3_ba = 3'd1;
            default: ddr3_ba = 3'd0;
          endcase
          // MR0: BL8, CL6, DLL reset
          if (mrs_idx == 2'd3) ddr3_addr = ROW_WIDTH'(14'h0520);
        end
        if (cnt == MOD_LAST) begin
          cnt_nxt = '0;
          if (mrs_idx == 2'd3) state_nxt = ZQ;
          else mrs_idx_nxt = mrs_idx + 2'd1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ZQ: begin
        if (cnt == '0) begin
          cmd           = C_ZQ;
          ddr3_addr[10] = 1'b1;
        end
        if (cnt == ZQ_LAST) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          init_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      IDLE: begin
        // Refresh wins over a request presented in the same cycle.
        if (ref_pend) begin
          cmd       = C_REF;
          ref_issue = 1'b1;
          state_nxt = REF_WAIT;
          cnt_nxt   = 16'd1;
        end else if (req_valid && !strobe_busy) begin
          req_ready = 1'b1;
          accept    = 1'b1;
          cmd       = C_ACT;
          ddr3_ba   = req_ba;
          ddr3_addr = req_row;
          state_nxt = ACT_WAIT;
          cnt_nxt   = 16'd1;
        end
      end
      ACT_WAIT: begin
        if (cnt == RCD_LAST) begin
          cmd           = lat_we ? C_WR : C_RD;
          wr_issue      = lat_we;
          rd_issue      = !lat_we;
          ddr3_ba       = lat_ba;
          ddr3_addr     = ROW_WIDTH'(lat_col);
          ddr3_addr[10] = 1'b1;
          state_nxt     = CAS_WAIT;
          cnt_nxt       = 16'd1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      CAS_WAIT: begin
        if (cnt == C2I_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      REF_WAIT: begin
        if (cnt == RFC_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = RST_HOLD;
    endcase
  end

  assign {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n} = cmd;
  assign init_calib_complete = init_done;

  // Refresh interval timer; a second expiry while pending is simply absorbed.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end else begin
      if (init_done) ref_cnt <= ref_expire ? 16'd0 : ref_cnt + 16'd1;
      ref_pend <= ref_expire | (ref_pend & ~ref_issue);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lat_we  <= 1'b0;
      lat_ba  <= '0;
      lat_col <= '0;
    end else if (accept) begin
      lat_we  <= req_we;
      lat_ba  <= req_ba;
      lat_col <= req_col;
    end
  end

  // Bit k of a shift register is set k+1 cycles after the CAS; the strobe
  // covers the four bits that correspond to latency .. latency+3.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_sr <= '0;
      rd_sr <= '0;
    end else begin
      wr_sr <= {wr_sr[CWL+1:0], wr_issue};
      rd_sr <= {rd_sr[CL+1:0], rd_issue};
    end
  end

  assign wr_data_en = |wr_sr[CWL+2:CWL-1];
  assign rd_capture = |rd_sr[CL+2:CL-1];

endmodule

// File: tb/tb_ddr3_cmd_sequencer.sv
// tb_ddr3_cmd_sequencer
//   Directed bench for ddr3_cmd_sequencer with default parameters: power-up
//   sequence timing, write, back-to-back reads, refresh priority and reset
//   in the middle of a write burst.
module tb_ddr3_cmd_sequencer;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_ZQ  = 4'b0110;

  logic        sys_clk, sys_rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_ba;
  logic [13:0] req_row;
  logic [9:0]  req_col;
  logic        ddr3_reset_n, ddr3_cke, ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n;
  logic [2:0]  ddr3_ba;
  logic [13:0] ddr3_addr;
  logic        init_calib_complete, wr_data_en, rd_capture;

  int cyc;
  int n_checks, n_errors;
  int cal_cyc;

  // trace results
  int          t_cas, t_wr_first, t_wr_last, t_wr_n, t_rd_first, t_rd_last, t_rd_n;
  int          t_rdy_n, t_ref_n;
  int          t_rdy [2];
  logic [3:0]  t_cas_cmd;
  logic [2:0]  t_cas_ba;
  logic [13:0] t_cas_addr;

  ddr3_cmd_sequencer dut (
    .sys_clk             (sys_clk),
    .sys_rst_n           (sys_rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_we              (req_we),
    .req_ba              (req_ba),
    .req_row             (req_row),
    .req_col             (req_col),
    .ddr3_reset_n        (ddr3_reset_n),
    .ddr3_cke            (ddr3_cke),
    .ddr3_cs_n           (ddr3_cs_n),
    .ddr3_ras_n          (ddr3_ras_n),
    .ddr3_cas_n          (ddr3_cas_n),
    .ddr3_we_n           (ddr3_we_n),
    .ddr3_ba             (ddr3_ba),
    .ddr3_addr           (ddr3_addr),
    .init_calib_complete (init_calib_complete),
    .wr_data_en          (wr_data_en),
    .rd_capture          (rd_capture)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  function automatic logic [3:0] cmd_now();
    return {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    cyc = cyc + 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reset_n"}, ddr3_reset_n, 0);
    check({tag, "_cke"}, ddr3_cke, 0);
    check({tag, "_cmd"}, cmd_now(), C_NOP);
    check({tag, "_ba"}, ddr3_ba, 0);
    check({tag, "_addr"}, ddr3_addr, 0);
    check({tag, "_calib"}, init_calib_complete, 0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_wde"}, wr_data_en, 0);
    check({tag, "_rdc"}, rd_capture, 0);
  endtask

  // Reset, release, and follow the power-up sequence until calibration ends.
  task automatic do_init(input bit full);
    int rst_rise, cke_rise, zq_cyc, zq_a10, n_mrs, bad_nop, bad_rdy, bad_strobe;
    int          mrs_cyc  [4];
    logic [2:0]  mrs_ba   [4];
    logic [13:0] mrs_addr [4];
    logic [2:0]  exp_ba   [4];
    logic [3:0]  c;
    exp_ba = '{3'd2, 3'd3, 3'd1, 3'd0};
    rst_rise = -1; cke_rise = -1; zq_cyc = -1; zq_a10 = 0; n_mrs = 0;
    bad_nop = 0; bad_rdy = 0; bad_strobe = 0; cal_cyc = -1;
    for (int k = 0; k < 4; k++) begin
      mrs_cyc[k] = -1; mrs_ba[k] = '0; mrs_addr[k] = '0;
    end
    req_valid = 1'b1; req_we = 1'b0; req_ba = 3'd0; req_row = '0; req_col = '0;
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1;
    check_reset_outputs("rst_hold");
    sys_rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 1100 && cal_cyc < 0; i++) begin
      if (i > 0) begin
        step();
        if (cyc >= 960) req_valid = 1'b0;
        #1;
      end
      c = cmd_now();
      if (rst_rise < 0 && ddr3_reset_n) rst_rise = cyc;
      if (cke_rise < 0 && ddr3_cke) cke_rise = cyc;
      if (c == C_MRS) begin
        if (n_mrs < 4) begin
          mrs_cyc[n_mrs] = cyc; mrs_ba[n_mrs] = ddr3_ba; mrs_addr[n_mrs] = ddr3_addr;
        end
        n_mrs++;
      end
      if (c == C_ZQ) begin
        zq_cyc = cyc; zq_a10 = int'(ddr3_addr[10]);
      end
      if (c == C_NOP && (ddr3_ba != 0 || ddr3_addr != 0)) bad_nop++;
      if (req_ready) bad_rdy++;
      if (wr_data_en || rd_capture) bad_strobe++;
      if (init_calib_complete) cal_cyc = cyc;
    end
    check("reset_n_rise", rst_rise, 200);
    check("calib_rise", cal_cyc, 964);
    check("ready_during_init", bad_rdy, 0);
    check("strobe_during_init", bad_strobe, 0);
    if (full) begin
      check("cke_rise", cke_rise, 400);
      check("mrs_count", n_mrs, 4);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("mrs%0d_ba", k), mrs_ba[k], exp_ba[k]);
        check($sformatf("mrs%0d_cyc", k), mrs_cyc[k], 400 + 13 * k);
        check($sformatf("mrs%0d_addr", k), mrs_addr[k], (k == 3) ? 32'h0520 : 32'h0);
      end
      check("zqcl_cyc", zq_cyc, 452);
      check("zqcl_a10", zq_a10, 1);
      check("nop_pins_zero", bad_nop, 0);
    end
  endtask

  // Follow the bus for n cycles after an acceptance. req_valid stays high
  // until max_acc requests (counting the one already accepted) are taken.
  task automatic trace(input int n, input int max_acc);
    logic [3:0] c;
    t_cas = -1; t_wr_first = -1; t_wr_last = -1; t_wr_n = 0;
    t_rd_first = -1; t_rd_last = -1; t_rd_n = 0; t_rdy_n = 0; t_ref_n = 0;
    t_rdy[0] = -1; t_rdy[1] = -1;
    t_cas_cmd = C_NOP; t_cas_ba = '0; t_cas_addr = '0;
    for (int i = 0; i < n; i++) begin
      step();
      req_valid = (t_rdy_n + 1 < max_acc);
      #1;
      c = cmd_now();
      if ((c == C_WR || c == C_RD) && t_cas < 0) begin
        t_cas = cyc; t_cas_cmd = c; t_cas_ba = ddr3_ba; t_cas_addr = ddr3_addr;
      end
      if (wr_data_en) begin
        if (t_wr_first < 0) t_wr_first = cyc;
        t_wr_last = cyc; t_wr_n++;
      end
      if (rd_capture) begin
        if (t_rd_first < 0) t_rd_first = cyc;
        t_rd_last = cyc; t_rd_n++;
      end
      if (req_ready) begin
        if (t_rdy_n < 2) t_rdy[t_rdy_n] = cyc;
        t_rdy_n++;
      end
      if (c == C_REF) t_ref_n++;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int a, r, rdy_at, ref_early;
    n_checks = 0; n_errors = 0; cyc = 0;
    sys_rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_ba = '0; req_row = '0; req_col = '0;

    // power-up with full sequence checks
    do_init(1'b1);

    // write ba=3 row=0x1234 col=0x08
    step();
    req_valid = 1'b1; req_we = 1'b1; req_ba = 3'd3; req_row = 14'h1234; req_col = 10'h008;
    #1;
    a = cyc;
    check("wr_ready", req_ready, 1);
    check("wr_act_cmd", cmd_now(), C_ACT);
    check("wr_act_ba", ddr3_ba, 3);
    check("wr_act_addr", ddr3_addr, 32'h1234);
    trace(40, 1);
    check("wr_cas_cyc", t_cas, a + 6);
    check("wr_cas_cmd", t_cas_cmd, C_WR);
    check("wr_cas_ba", t_cas_ba, 3);
    check("wr_cas_addr", t_cas_addr, 32'h0408);
    check("wr_en_first", t_wr_first, a + 11);
    check("wr_en_last", t_wr_last, a + 14);
    check("wr_en_count", t_wr_n, 4);
    check("wr_no_rdcap", t_rd_n, 0);

    // three reads ba=0 row=1 col=0x10 with req_valid held
    step();
    req_valid = 1'b1; req_we = 1'b0; req_ba = 3'd0; req_row = 14'd1; req_col = 10'h010;
    #1;
    a = cyc;
    check("rd_ready", req_ready, 1);
    check("rd_act_addr", ddr3_addr, 32'h0001);
    trace(80, 3);
    check("rd_cas_cyc", t_cas, a + 6);
    check("rd_cas_cmd", t_cas_cmd, C_RD);
    check("rd_cas_ba", t_cas_ba, 0);
    check("rd_cas_addr", t_cas_addr, 32'h0410);
    check("rd_cap_first", t_rd_first, a + 12);
    check("rd_cap_last", t_rd_last, a + 54 + 15);
    check("rd_cap_count", t_rd_n, 12);
    check("b2b_ready_count", t_rdy_n, 2);
    check("b2b_ready_2nd", t_rdy[0], a + 27);
    check("b2b_ready_3rd", t_rdy[1], a + 54);
    check("rd_no_wde", t_wr_n, 0);

    // refresh expires T_REFI cycles after calibration, together with a request
    r = cal_cyc + 3120;
    ref_early = 0;
    while (cyc < r - 1) begin
      step();
      #1;
      if (cmd_now() == C_REF) ref_early++;
    end
    check("no_early_ref", ref_early, 0);
    step();
    req_valid = 1'b1; req_we = 1'b0; req_ba = 3'd1; req_row = 14'd5; req_col = 10'd2;
    #1;
    check("ref_cmd", cmd_now(), C_REF);
    check("ref_blocks_ready", req_ready, 0);
    rdy_at = -1;
    for (int i = 0; i < 100 && rdy_at < 0; i++) begin
      step();
      #1;
      if (req_ready) rdy_at = cyc;
    end
    check("ref_then_ready", rdy_at, r + 64);
    check("ref_then_act", cmd_now(), C_ACT);
    check("ref_act_addr", ddr3_addr, 32'h0005);
    trace(40, 1);
    check("ref_req_cas", t_cas_addr, 32'h0402);
    check("ref_req_rdcount", t_rd_n, 4);

    // reset while the write strobe is active in CAS_WAIT
    step();
    req_valid = 1'b1; req_we = 1'b1; req_ba = 3'd2; req_row = 14'd7; req_col = 10'd3;
    #1;
    a = cyc;
    check("rst_wr_ready", req_ready, 1);
    while (cyc < a + 12) begin
      step();
      req_valid = 1'b0;
    end
    #1;
    check("rst_pre_wde", wr_data_en, 1);
    sys_rst_n = 1'b0;
    req_valid = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    do_init(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
